// File: rtl/pipe_hazard_ctrl.sv
// Purpose: hazard/control unit for a 5-stage pipeline (load-use, mispredict, ret, halt).
// Latency: control outputs are combinational from state+inputs; state/stall_cnt update next edge.
// Backpressure: drives stalls/bubbles into the pipeline registers; no upstream handshake.
//
// Ports:
//   clk, rst                  : clock, synchronous active-high reset
//   D_icode, d_srcA, d_srcB   : Decode-stage opcode and source registers
//   E_icode, E_dstM, e_cnd    : Execute-stage opcode, load destination, branch condition
//   m_stat, W_stat            : Memory / Writeback status codes
//   F_stall..W_stall, set_cc  : per-stage stall/bubble controls, CC write enable
//   halted                    : high while the controller sits in HALTED
//   stall_cnt                 : saturating count of Fetch-stall cycles (not counted in HALTED)
module pipe_hazard_ctrl #(
  parameter logic [2:0] STAT_AOK = 3'd1,
  parameter logic [3:0] RNONE    = 4'hF,
  parameter int         CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       D_icode,
  input  logic [3:0]       d_srcA,
  input  logic [3:0]       d_srcB,
  input  logic [3:0]       E_icode,
  input  logic [3:0]       E_dstM,
  input  logic             e_cnd,
  input  logic [2:0]       m_stat,
  input  logic [2:0]       W_stat,
  output logic             F_stall,
  output logic             D_stall,
  output logic             D_bubble,
  output logic             E_bubble,
  output logic             M_bubble,
  output logic             W_stall,
  output logic             set_cc,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    RET_E  = 2'd1,
    RET_M  = 2'd2,
    HALTED = 2'd3
  } state_t;

  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_POPQ   = 4'hB;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic load_use, mispredict, ret_in_d;

  // A load in Execute whose destination feeds Decode; RNONE never matches.
  assign load_use   = ((E_icode == I_MRMOVQ) || (E_icode == I_POPQ)) &&
                      (E_dstM != RNONE) &&
                      ((E_dstM == d_srcA) || (E_dstM == d_srcB));
  assign mispredict = (E_icode == I_JXX) && !e_cnd;
  assign ret_in_d   = (D_icode == I_RET);

  always_comb begin
    state_d  = state_q;
    F_stall  = 1'b0;
    D_stall  = 1'b0;
    D_bubble = 1'b0;
    E_bubble = 1'b0;
    M_bubble = 1'b0;
    W_stall  = 1'b0;
    set_cc   = 1'b0;

    if (rst) begin
      // Flush the datapath stages while reset is held.
      D_bubble = 1'b1;
      E_bubble = 1'b1;
      M_bubble = 1'b1;
      state_d  = RUN;
    end else begin
      unique case (state_q)
        RUN: begin
          if (load_use) begin
            // Load-use wins over ret: the ret is re-examined once the load resolves.
            F_stall  = 1'b1;
            D_stall  = 1'b1;
            E_bubble = 1'b1;
          end else if (mispredict) begin
            // Squash the two wrong-path instructions; a ret among them is discarded.
            D_bubble = 1'b1;
            E_bubble = 1'b1;
          end else if (ret_in_d) begin
            F_stall  = 1'b1;
            D_bubble = 1'b1;
            state_d  = RET_E;
          end
        end
        RET_E: begin
          F_stall  = 1'b1;
          D_bubble = 1'b1;
          state_d  = RET_M;
        end
        RET_M: begin
          F_stall  = 1'b1;
          D_bubble = 1'b1;
          state_d  = RUN;
        end
        HALTED: begin
          F_stall = 1'b1;
          D_stall = 1'b1;
          W_stall = 1'b1;
        end
        default: state_d = RUN;
      endcase

      if (state_q != HALTED) begin
        M_bubble = (m_stat != STAT_AOK);
        set_cc   = (E_icode == I_OPQ) && (m_stat == STAT_AOK) && (W_stat == STAT_AOK);
      end

      // A faulting instruction at Writeback freezes the machine, overriding ret sequencing.
      if (W_stat != STAT_AOK) begin
        W_stall = 1'b1;
        state_d = HALTED;
      end
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (rst) begin
      stall_cnt_d = '0;
    end else if (F_stall && (state_q != HALTED) && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign halted    = (state_q == HALTED);
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] D_icode, d_srcA, d_srcB, E_icode, E_dstM;
  logic       e_cnd;
  logic [2:0] m_stat, W_stat;

  logic        F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc, halted;
  logic [15:0] stall_cnt;

  logic        s_F_stall, s_D_stall, s_D_bubble, s_E_bubble, s_M_bubble, s_W_stall, s_set_cc, s_halted;
  logic [1:0]  s_stall_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl dut (
    .clk(clk), .rst(rst),
    .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
    .E_icode(E_icode), .E_dstM(E_dstM), .e_cnd(e_cnd),
    .m_stat(m_stat), .W_stat(W_stat),
    .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble), .E_bubble(E_bubble),
    .M_bubble(M_bubble), .W_stall(W_stall), .set_cc(set_cc), .halted(halted),
    .stall_cnt(stall_cnt)
  );

  // Narrow counter instance used only to observe saturation.
  pipe_hazard_ctrl #(.CNT_W(2)) u_sat (
    .clk(clk), .rst(rst),
    .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
    .E_icode(E_icode), .E_dstM(E_dstM), .e_cnd(e_cnd),
    .m_stat(m_stat), .W_stat(W_stat),
    .F_stall(s_F_stall), .D_stall(s_D_stall), .D_bubble(s_D_bubble), .E_bubble(s_E_bubble),
    .M_bubble(s_M_bubble), .W_stall(s_W_stall), .set_cc(s_set_cc), .halted(s_halted),
    .stall_cnt(s_stall_cnt)
  );

  // {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc}
  function automatic logic [6:0] ctl();
    return {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc};
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic nop_inputs();
    D_icode = 4'h1; d_srcA = 4'hF; d_srcB = 4'hF;
    E_icode = 4'h1; E_dstM = 4'hF; e_cnd = 1'b1;
    m_stat  = 3'd1; W_stat = 3'd1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    nop_inputs();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    string      name;
    logic [3:0] D_icode, d_srcA, d_srcB, E_icode, E_dstM;
    logic       e_cnd;
    logic [2:0] m_stat;
    logic [6:0] exp;
  } vec_t;

  vec_t vecs[11];

  initial begin
    //        name          Dic   srcA  srcB  Eic   dstM  cnd   m     {F D Db Eb Mb Ws cc}
    vecs[0]  = '{"nop",      4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1'b1, 3'd1, 7'b0000000};
    vecs[1]  = '{"lu_mrmov", 4'h1, 4'h3, 4'hF, 4'h5, 4'h3, 1'b1, 3'd1, 7'b1101000};
    vecs[2]  = '{"lu_popq",  4'h1, 4'hF, 4'h4, 4'hB, 4'h4, 1'b1, 3'd1, 7'b1101000};
    vecs[3]  = '{"lu_rnone", 4'h1, 4'hF, 4'hF, 4'hB, 4'hF, 1'b1, 3'd1, 7'b0000000};
    vecs[4]  = '{"lu_nomat", 4'h1, 4'h2, 4'h4, 4'h5, 4'h3, 1'b1, 3'd1, 7'b0000000};
    vecs[5]  = '{"mp_ret",   4'h9, 4'hF, 4'hF, 4'h7, 4'hF, 1'b0, 3'd1, 7'b0011000};
    vecs[6]  = '{"jmp_ok",   4'h1, 4'hF, 4'hF, 4'h7, 4'hF, 1'b1, 3'd1, 7'b0000000};
    vecs[7]  = '{"cc_ok",    4'h1, 4'hF, 4'hF, 4'h6, 4'hF, 1'b1, 3'd1, 7'b0000001};
    vecs[8]  = '{"cc_mbad",  4'h1, 4'hF, 4'hF, 4'h6, 4'hF, 1'b1, 3'd3, 7'b0000100};
    vecs[9]  = '{"lu_ret",   4'h9, 4'h3, 4'hF, 4'h5, 4'h3, 1'b1, 3'd1, 7'b1101000};
    vecs[10] = '{"after",    4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1'b1, 3'd1, 7'b0000000};

    rst = 1'b1;
    nop_inputs();

    // Reset-time outputs and post-reset state.
    @(negedge clk);
    #1;
    check("rst_ctl", {9'd0, ctl()}, {9'd0, 7'b0011100});
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_halted", {15'd0, halted}, 16'd0);
    check("rst_cnt", stall_cnt, 16'd0);
    check("rst_idle_ctl", {9'd0, ctl()}, 16'd0);

    // Table: single-cycle behaviour in RUN (no vector leaves RUN).
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      D_icode = vecs[i].D_icode; d_srcA = vecs[i].d_srcA; d_srcB = vecs[i].d_srcB;
      E_icode = vecs[i].E_icode; E_dstM = vecs[i].E_dstM; e_cnd = vecs[i].e_cnd;
      m_stat  = vecs[i].m_stat;  W_stat = 3'd1;
      #1;
      check(vecs[i].name, {9'd0, ctl()}, {9'd0, vecs[i].exp});
    end
    @(negedge clk);
    nop_inputs();
    #1;
    check("cnt_after_tbl", stall_cnt, 16'd3);
    check("sat_cnt_3", {14'd0, s_stall_cnt}, 16'd3);

    // One more load-use stall: wide counter moves on, narrow one holds at all-ones.
    E_icode = 4'h5; E_dstM = 4'h2; d_srcA = 4'h2;
    @(negedge clk);
    nop_inputs();
    #1;
    check("cnt_4", stall_cnt, 16'd4);
    check("sat_hold", {14'd0, s_stall_cnt}, 16'd3);

    // Ret sequence: exactly three stall/bubble cycles.
    do_reset();
    D_icode = 4'h9;
    for (int c = 0; c < 4; c++) begin
      #1;
      check($sformatf("ret_c%0d", c), {9'd0, ctl()}, (c < 3) ? 16'b1010000 : 16'd0);
      @(negedge clk);
      D_icode = 4'h1;
    end
    #1;
    check("ret_cnt", stall_cnt, 16'd3);

    // Halt during RET_M, stickiness, then reset recovery.
    do_reset();
    D_icode = 4'h9;
    @(negedge clk);
    D_icode = 4'h1;
    @(negedge clk);
    W_stat = 3'd2;
    #1;
    check("retm_wbad", {9'd0, ctl()}, {9'd0, 7'b1010010});
    check("retm_not_halted", {15'd0, halted}, 16'd0);
    @(negedge clk);
    W_stat = 3'd1; E_icode = 4'h6; m_stat = 3'd3;
    #1;
    check("halted_1", {15'd0, halted}, 16'd1);
    check("halted_ctl", {9'd0, ctl()}, {9'd0, 7'b1100010});
    @(negedge clk);
    m_stat = 3'd1;
    #1;
    check("halted_sticky", {15'd0, halted}, 16'd1);
    check("halted_ctl2", {9'd0, ctl()}, {9'd0, 7'b1100010});
    check("halted_nocnt", stall_cnt, 16'd3);
    @(negedge clk);
    rst = 1'b1;
    nop_inputs();
    #1;
    check("halt_rst_ctl", {9'd0, ctl()}, {9'd0, 7'b0011100});
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("unhalt", {15'd0, halted}, 16'd0);
    check("unhalt_cnt", stall_cnt, 16'd0);
    check("unhalt_ctl", {9'd0, ctl()}, 16'd0);

    // Back in RUN: a ret starts a fresh sequence.
    D_icode = 4'h9;
    @(negedge clk);
    D_icode = 4'h1;
    #1;
    check("run_again_rete", {9'd0, ctl()}, {9'd0, 7'b1010000});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 The block SHALL use these parameters (name, default, meaning):
- STAT_AOK, 3'd1, normal status
- RNONE, 4'hF, no-register ID
- CNT_W, 16, stall-counter width
REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, clock; all state updates on its rising edge
- rst, in, 1, synchronous active-high reset
- D_icode, in, 4, icode in Decode
- d_srcA, in, 4, Decode source A register
- d_srcB, in, 4, Decode source B register
- E_icode, in, 4, icode in Execute
- E_dstM, in, 4, Execute memory-destination register
- e_cnd, in, 1, condition result from the execute stage
- m_stat, in, 3, Memory-stage status
- W_stat, in, 3, Writeback-stage status
- F_stall, out, 1, hold the Fetch register
- D_stall, out, 1, hold the Decode register
- D_bubble, out, 1, load a nop into Decode
- E_bubble, out, 1, load a nop into Execute
- M_bubble, out, 1, load a nop into Memory
- W_stall, out, 1, hold the Writeback register
- set_cc, out, 1, condition-code write enable for the execute stage
- halted, out, 1, sticky: processor stopped
- stall_cnt, out, CNT_W, saturating count of F_stall cycles

Function
REQ-004 The block SHALL hold a registered state, one of: RUN, RET_E, RET_M, HALTED.
REQ-005 Control outputs SHALL be combinational from the current state and inputs; only the state, stall_cnt and halted SHALL be registered.
REQ-006 Load-use (LU) SHALL be true when all of the following hold:
- E_icode is 5 (mrmovq) or B (popq)
- E_dstM != RNONE
- E_dstM equals d_srcA or d_srcB
REQ-007 Mispredict (MP) SHALL be true when E_icode==7 and e_cnd==0.
REQ-008 RETD SHALL be true when D_icode==9.
REQ-009 In RUN with LU, the block SHALL assert F_stall=1, D_stall=1 and E_bubble=1, with D_bubble=0.
REQ-010 In RUN with MP, the block SHALL assert D_bubble=1 and E_bubble=1, with F_stall=0; MP takes priority over RETD.
REQ-011 In RUN with RETD, !LU and !MP, the block SHALL assert F_stall=1 and D_bubble=1, and SHALL move the state to RET_E next cycle.
REQ-012 In RUN with RETD and LU, LU handling SHALL apply and the state SHALL remain RUN.
REQ-013 In RET_E, the block SHALL assert F_stall=1 and D_bubble=1, and the next state SHALL be RET_M.
REQ-014 In RET_M, the block SHALL assert F_stall=1 and D_bubble=1, and the next state SHALL be RUN.
REQ-015 A return sequence SHALL therefore produce exactly 3 consecutive F_stall/D_bubble cycles.
REQ-016 set_cc SHALL be 1 only when all of the following hold:
- E_icode==6
- m_stat==STAT_AOK
- W_stat==STAT_AOK
- state != HALTED
REQ-017 When m_stat != STAT_AOK, M_bubble SHALL be 1.
REQ-018 When W_stat != STAT_AOK in any state, the block SHALL assert W_stall=1, and the next state SHALL be HALTED.
REQ-019 W_stat exception handling SHALL override RET_E/RET_M sequencing.
REQ-020 In HALTED, the block SHALL assert F_stall, D_stall and W_stall =1, with all bubbles 0 and set_cc=0.
REQ-021 HALTED SHALL be left only by reset, and halted SHALL be 1 whenever the state is HALTED.
REQ-022 All control outputs not asserted by REQ-009..REQ-020 SHALL be 0.
REQ-023 Whenever F_stall=1, stall_cnt SHALL increment by 1 per cycle, saturating at all-ones with no wrap.
REQ-024 stall_cnt SHALL NOT count cycles in HALTED.

Reset
REQ-025 With rst=1 at a clock edge, next-cycle values SHALL be:
- state = RUN
- halted = 0
- stall_cnt = 0
REQ-026 While rst=1, the block SHALL drive:
- D_bubble = E_bubble = M_bubble = 1
- F_stall = D_stall = W_stall = 0
- set_cc = 0
REQ-027 Reset during RET_E, RET_M or HALTED SHALL return the block to RUN in one cycle.

Verification
REQ-028 Load-use: E_icode=5, E_dstM=3, d_srcA=3 -> F_stall=1, D_stall=1, E_bubble=1, D_bubble=0; stall_cnt +1.
REQ-029 No load-use on RNONE: E_icode=B, E_dstM=F, d_srcB=F -> all control outputs 0.
REQ-030 Mispredict: E_icode=7, e_cnd=0, D_icode=9 -> D_bubble=1, E_bubble=1; state stays RUN; no ret sequence.
REQ-031 Ret: D_icode=9 for one cycle, then D_icode=1 -> F_stall=1, D_bubble=1 for exactly 3 cycles, then 0; stall_cnt=3.
REQ-032 CC gating: E_icode=6 with m_stat=1 -> set_cc=1; then m_stat=3 -> set_cc=0 and M_bubble=1.
REQ-033 Halt and reset: W_stat=2 during RET_M -> W_stall=1, then halted=1 with F/D/W stalls held; rst=1 for one cycle -> halted=0, state RUN, stall_cnt=0.
